// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the datapath control bus: three-cycle fetch,
// three-cycle R-type ALU execute, plus nop, halt and illegal-opcode handling.
module control_sequencer #(
    parameter logic [15:0] ALU_INCPC = 16'd0,
    parameter logic [15:0] ALU_ADD   = 16'd12,
    parameter logic [15:0] ALU_SUB   = 16'd13,
    parameter logic [15:0] ALU_AND   = 16'd10,
    parameter logic [15:0] ALU_OR    = 16'd11,
    parameter logic [15:0] ALU_SHR   = 16'd6,
    parameter logic [15:0] ALU_SHL   = 16'd7
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic [31:0] Rin,
    output logic [31:0] Rout,
    output logic        IRin,
    output logic        MARin,
    output logic        RYin,
    output logic        MDRread,
    output logic        RZout,
    output logic        RBin,
    output logic        PCjump,
    output logic [15:0] ALUControl,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam int         ZLOW    = 19;
    localparam int         PC_BIT  = 20;
    localparam int         MDR_BIT = 21;

    state_t      state_r;
    logic [4:0]  op_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        unused_ir_s;

    assign op_s        = IR[31:27];
    assign ra_s        = IR[26:23];
    assign rb_s        = IR[22:19];
    assign rc_s        = IR[18:15];
    assign unused_ir_s = ^IR[14:0];

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= 5'b00010) && (op <= 5'b00111);
    endfunction

    function automatic logic [15:0] alu_code(input logic [4:0] op);
        logic [15:0] code;
        case (op)
            5'b00010: code = ALU_ADD;
            5'b00011: code = ALU_SUB;
            5'b00100: code = ALU_AND;
            5'b00101: code = ALU_OR;
            5'b00110: code = ALU_SHR;
            5'b00111: code = ALU_SHL;
            default:  code = 16'd0;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] reg_sel(input logic [3:0] idx);
        return 32'd1 << idx;
    endfunction

    // State register: one state per clock, run only matters in IDLE, HALT exits only via clear
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_r <= run ? S_T0 : S_IDLE;
                S_T0:    state_r <= S_T1;
                S_T1:    state_r <= S_T2;
                S_T2:    state_r <= S_T3;
                S_T3: begin
                    if (is_alu_op(op_s)) begin
                        state_r <= S_T4;
                    end else if (op_s == OP_HALT) begin
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_T0;
                    end
                end
                S_T4:    state_r <= S_T5;
                S_T5:    state_r <= S_T0;
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Control bus decode from current state and the fed-back instruction word
    always_comb begin
        Rin        = 32'd0;
        Rout       = 32'd0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        RYin       = 1'b0;
        MDRread    = 1'b0;
        RZout      = 1'b0;
        RBin       = 1'b0;
        PCjump     = 1'b0;
        ALUControl = 16'd0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        case (state_r)
            S_T0: begin
                Rout[PC_BIT] = 1'b1;
                MARin        = 1'b1;
                Rin[ZLOW]    = 1'b1;
                ALUControl   = ALU_INCPC;
            end
            S_T1: begin
                Rout[ZLOW]   = 1'b1;
                Rin[PC_BIT]  = 1'b1;
                MDRread      = 1'b1;
                Rin[MDR_BIT] = 1'b1;
            end
            S_T2: begin
                Rout[MDR_BIT] = 1'b1;
                IRin          = 1'b1;
            end
            S_T3: begin
                if (is_alu_op(op_s)) begin
                    Rout = reg_sel(rb_s);
                    RYin = 1'b1;
                end else if ((op_s == OP_NOP) || (op_s == OP_HALT)) begin
                    instr_done = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_T4: begin
                Rout       = reg_sel(rc_s);
                ALUControl = alu_code(op_s);
                Rin[ZLOW]  = 1'b1;
            end
            S_T5: begin
                Rout[ZLOW] = 1'b1;
                Rin        = reg_sel(ra_s);
                instr_done = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                Rin = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural datapath/memory model plus a per-instruction
// expected control-word list derived from the instruction fields.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir_bus;
    logic [31:0] Rin, Rout;
    logic        IRin, MARin, RYin, MDRread, RZout, RBin, PCjump;
    logic [15:0] ALUControl;
    logic        instr_done, illegal_op, halted;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .IR(ir_bus),
        .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RYin(RYin),
        .MDRread(MDRread), .RZout(RZout), .RBin(RBin), .PCjump(PCjump),
        .ALUControl(ALUControl), .instr_done(instr_done),
        .illegal_op(illegal_op), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] rin;
        logic [31:0] rout;
        logic        irin, marin, ryin, mdrread, rzout, rbin, pcjump;
        logic [15:0] alu;
        logic        done, ill, hlt;
    } ctl_t;

    logic [31:0] R [16];
    logic [31:0] mem [256];
    logic [31:0] pc_m, mar_m, mdr_m, z_m, y_m;
    ctl_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    function automatic ctl_t obs_now();
        ctl_t o;
        o.rin = Rin; o.rout = Rout; o.irin = IRin; o.marin = MARin; o.ryin = RYin;
        o.mdrread = MDRread; o.rzout = RZout; o.rbin = RBin; o.pcjump = PCjump;
        o.alu = ALUControl; o.done = instr_done; o.ill = illegal_op; o.hlt = halted;
        return o;
    endfunction

    function automatic bit is_alu(input logic [4:0] op);
        return (op >= 5'd2) && (op <= 5'd7);
    endfunction

    function automatic logic [15:0] code_of(input logic [4:0] op);
        case (op)
            5'd2:    return 16'd12;
            5'd3:    return 16'd13;
            5'd4:    return 16'd10;
            5'd5:    return 16'd11;
            5'd6:    return 16'd6;
            5'd7:    return 16'd7;
            default: return 16'd0;
        endcase
    endfunction

    // Architectural result of an R-type op, from the opcode alone
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd2:    return a + b;
            5'd3:    return a - b;
            5'd4:    return a & b;
            5'd5:    return a | b;
            5'd6:    return a >> b;
            5'd7:    return a << b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] dp_alu(input logic [15:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            16'd0:   return b + 32'd1;
            16'd12:  return a + b;
            16'd13:  return a - b;
            16'd10:  return a & b;
            16'd11:  return a | b;
            16'd6:   return a >> b;
            16'd7:   return a << b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [95:0] o, input logic [95:0] e);
        n_checks++;
        assert (o === e) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic apply_dp(input ctl_t c);
        logic [31:0] bus;
        logic [31:0] mar_o;
        bus = 32'd0;
        for (int i = 0; i < 16; i++) if (c.rout[i]) bus |= R[i];
        if (c.rout[19]) bus |= z_m;
        if (c.rout[20]) bus |= pc_m;
        if (c.rout[21]) bus |= mdr_m;
        mar_o = mar_m;
        if (c.marin)   mar_m = bus;
        if (c.rin[19]) z_m = dp_alu(c.alu, y_m, bus);
        if (c.rin[20]) pc_m = bus;
        if (c.rin[21]) mdr_m = c.mdrread ? mem[mar_o[7:0]] : bus;
        if (c.irin)    ir_bus = bus;
        if (c.ryin)    y_m = bus;
        for (int i = 0; i < 16; i++) if (c.rin[i]) R[i] = bus;
    endtask

    // Advance one clock: strobes seen before the edge act on the datapath model at the edge
    task automatic tick();
        ctl_t c;
        c = obs_now();
        @(posedge clock);
        apply_dp(c);
        @(negedge clock);
    endtask

    task automatic build_exp(input logic [31:0] instr);
        ctl_t w;
        logic [4:0] op;
        op = instr[31:27];
        exp_q.delete();
        w = '0; w.rout[20] = 1'b1; w.marin = 1'b1; w.rin[19] = 1'b1; exp_q.push_back(w);
        w = '0; w.rout[19] = 1'b1; w.rin[20] = 1'b1; w.mdrread = 1'b1; w.rin[21] = 1'b1; exp_q.push_back(w);
        w = '0; w.rout[21] = 1'b1; w.irin = 1'b1; exp_q.push_back(w);
        if (is_alu(op)) begin
            w = '0; w.rout[instr[22:19]] = 1'b1; w.ryin = 1'b1; exp_q.push_back(w);
            w = '0; w.rout[instr[18:15]] = 1'b1; w.alu = code_of(op); w.rin[19] = 1'b1; exp_q.push_back(w);
            w = '0; w.rout[19] = 1'b1; w.rin[instr[26:23]] = 1'b1; w.done = 1'b1; exp_q.push_back(w);
        end else if (op == 5'b11010 || op == 5'b11011) begin
            w = '0; w.done = 1'b1; exp_q.push_back(w);
        end else begin
            w = '0; w.done = 1'b1; w.ill = 1'b1; exp_q.push_back(w);
        end
    endtask

    // Entered at a falling edge with the sequencer in T0; leaves at the next T0 (or HALT)
    task automatic do_instr(input logic [31:0] instr);
        logic [31:0] pc0, a, b;
        logic [4:0]  op;
        op  = instr[31:27];
        mem[pc_m[7:0]] = instr;
        build_exp(instr);
        pc0 = pc_m;
        a = R[instr[22:19]];
        b = R[instr[18:15]];
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("ctl_T%0d_op%0h", k, op), {6'd0, obs_now()}, {6'd0, exp_q[k]});
            run = 1'($urandom_range(0, 1));
            tick();
        end
        run = 1'b0;
        check($sformatf("pc_inc_op%0h", op), {64'd0, pc_m}, {64'd0, pc0 + 32'd1});
        if (is_alu(op))
            check($sformatf("alu_result_op%0h", op), {64'd0, R[instr[26:23]]}, {64'd0, ref_result(op, a, b)});
    endtask

    function automatic logic [31:0] rand_alu();
        logic [4:0] op;
        op = 5'($urandom_range(2, 7));
        return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    task automatic seed_operands(input logic [31:0] instr);
        R[instr[22:19]] = $urandom;
        if (instr[31:27] == 5'd6 || instr[31:27] == 5'd7)
            R[instr[18:15]] = 32'($urandom_range(0, 31));
        else
            R[instr[18:15]] = $urandom;
    endtask

    initial begin
        logic [31:0] instr, z_before;
        logic [4:0]  op;
        ctl_t        w;
        clear = 1'b1; run = 1'b1; ir_bus = 32'd0;
        for (int i = 0; i < 16; i++) R[i] = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        pc_m = 32'd0; mar_m = 32'd0; mdr_m = 32'd0; z_m = 32'd0; y_m = 32'd0;

        repeat (2) @(negedge clock);
        check("reset_idle", {6'd0, obs_now()}, 96'd0);
        @(negedge clock);
        check("clear_over_run", {6'd0, obs_now()}, 96'd0);
        clear = 1'b0; run = 1'b0;
        tick();
        check("idle_no_run", {6'd0, obs_now()}, 96'd0);
        run = 1'b1; tick(); run = 1'b0;

        R[5] = 32'h34; R[6] = 32'h45;
        do_instr(32'h112B_0000);
        check("add_r2", {64'd0, R[2]}, {64'd0, 32'h79});

        R[0] = 32'h1000; R[15] = 32'h0123;
        do_instr(32'h1F87_8000);
        check("sub_r15", {64'd0, R[15]}, {64'd0, 32'h0EDD});

        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                instr = rand_alu();
                seed_operands(instr);
            end else if (kind == 7) begin
                instr = {5'b11010, 27'($urandom)};
            end else begin
                do op = 5'($urandom_range(0, 31)); while (is_alu(op) || op == 5'd26 || op == 5'd27);
                instr = {op, 27'($urandom)};
            end
            do_instr(instr);
        end

        do_instr(32'hF800_0000);
        do_instr(32'hD000_0000);

        instr = rand_alu();
        seed_operands(instr);
        mem[pc_m[7:0]] = instr;
        build_exp(instr);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pre_clear_T%0d", k), {6'd0, obs_now()}, {6'd0, exp_q[k]});
            tick();
        end
        check("pre_clear_T4", {6'd0, obs_now()}, {6'd0, exp_q[4]});
        #2 clear = 1'b1;
        #1 check("clear_async_mid_T4", {6'd0, obs_now()}, 96'd0);
        z_before = z_m;
        tick();
        check("z_not_loaded", {64'd0, z_m}, {64'd0, z_before});
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("idle_after_clear_%0d", k), {6'd0, obs_now()}, 96'd0);
            tick();
        end
        run = 1'b1; tick(); run = 1'b0;
        instr = rand_alu();
        seed_operands(instr);
        do_instr(instr);

        do_instr(32'hD800_0000);
        w = '0; w.hlt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halted_%0d", k), {6'd0, obs_now()}, {6'd0, w});
            run = 1'($urandom_range(0, 1));
            tick();
        end
        run = 1'b0;
        clear = 1'b1;
        #1 check("halt_cleared", {6'd0, obs_now()}, 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
